mpeg2enc_ctrl: RTL

Memory-mapped control/status front end for the MPEG-2 encoder core. Generalises the 2-buffer ping-pong scheme to NUM_BUFS frame buffers, with:
- host-side fill tracking
- a round-robin job sequencer that hands buffers to the encode engine
- single-shot and continuous modes
- a frame counter and sticky error flags

Sits between the HPS bridge slave port and the encoder datapath.

---
 rtl/mpeg2enc_pkg.sv | 30 +++
 rtl/mpeg2enc_bufring.sv | 37 +++
 rtl/mpeg2enc_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mpeg2enc_pkg.sv
// Shared types and constants for the MPEG-2 encoder control front end.
package mpeg2enc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    BUSY   = 2'd2,
    RETIRE = 2'd3
  } state_t;

  localparam int unsigned REG_CTRL     = 0;
  localparam int unsigned REG_FILL     = 1;
  localparam int unsigned REG_FRAMES   = 2;
  localparam int unsigned REG_ERR      = 3;
  localparam int unsigned REG_IRQ      = 4;
  localparam int unsigned REG_IRQ_MASK = 5;

  // CTRL write bits
  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_ABORT = 1;
  localparam int unsigned CTRL_CONT  = 2;

  // STATUS read field positions
  localparam int unsigned ST_IDLE  = 0;
  localparam int unsigned ST_STATE = 4;
  localparam int unsigned ST_CONT  = 6;
  localparam int unsigned ST_FULL  = 8;
  localparam int unsigned ST_PTR   = 16;

endpackage

// File: rtl/mpeg2enc_bufring.sv
// Frame-buffer ring: full mask, job pointer and wrap logic.
module mpeg2enc_bufring
  import mpeg2enc_pkg::*;
#(
  parameter int unsigned NUM_BUFS = 2,
  parameter int unsigned BI_W     = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [NUM_BUFS-1:0] set_mask,
  input  logic                clr,
  input  logic                adv,
  output logic [NUM_BUFS-1:0] full,
  output logic [BI_W-1:0]     ptr,
  output logic [BI_W-1:0]     next_ptr
);

  logic [NUM_BUFS-1:0] clr_mask;

  always_comb begin
    next_ptr = (ptr == BI_W'(NUM_BUFS - 1)) ? '0 : ptr + BI_W'(1);
    clr_mask = '0;
    if (clr) clr_mask[ptr] = 1'b1;
  end

  // A same-cycle set overrides the retire clear of the same bit.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      full <= '0;
      ptr  <= '0;
    end else begin
      full <= (full & ~clr_mask) | set_mask;
      if (adv) ptr <= next_ptr;
    end
  end

endmodule

// File: rtl/mpeg2enc_ctrl.sv
// Register front end and job sequencer for the MPEG-2 encoder core.
// Optional interrupt logic and irq port: define MPEG2ENC_IRQ_EN.
module mpeg2enc_ctrl
  import mpeg2enc_pkg::*;
#(
  parameter int unsigned NUM_BUFS = 2,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned BI_W    = $clog2(NUM_BUFS)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [31:0]       dataIn,
  output logic [31:0]       dataOut,
  output logic              eng_start,
  output logic [BI_W-1:0]   eng_buf,
  output logic              eng_abort,
  input  logic              eng_done
`ifdef MPEG2ENC_IRQ_EN
  ,
  output logic              irq
`endif
);

  state_t              state;
  logic                cont;
  logic [CNT_W-1:0]    frame_cnt;
  logic [1:0]          err;
  logic [NUM_BUFS-1:0] full, set_mask, busy_mask, retire_mask;
  logic [BI_W-1:0]     ptr, next_ptr;
  logic wr_ctrl, wr_fill, wr_frames, wr_err;
  logic abort_req, start_req, retire_go, nobuf_ev, ovr_ev;
  logic unused_din;

  assign unused_din = ^dataIn;

  assign wr_ctrl   = wr_en && (addr == ADDR_W'(REG_CTRL));
  assign wr_fill   = wr_en && (addr == ADDR_W'(REG_FILL));
  assign wr_frames = wr_en && (addr == ADDR_W'(REG_FRAMES));
  assign wr_err    = wr_en && (addr == ADDR_W'(REG_ERR));

  assign abort_req = wr_ctrl && dataIn[CTRL_ABORT];
  assign start_req = wr_ctrl && dataIn[CTRL_START] && !dataIn[CTRL_ABORT];
  assign retire_go = (state == RETIRE) && !abort_req;
  assign set_mask  = wr_fill ? dataIn[NUM_BUFS-1:0] : '0;
  assign nobuf_ev  = start_req && (state == IDLE) && !full[ptr];

  // The bit being retired this cycle does not count as already full.
  always_comb begin
    busy_mask   = '0;
    retire_mask = '0;
    if (state == ISSUE || state == BUSY) busy_mask[eng_buf] = 1'b1;
    if (retire_go) retire_mask[ptr] = 1'b1;
  end
  assign ovr_ev = |(set_mask & ((full & ~retire_mask) | busy_mask));

  mpeg2enc_bufring #(
    .NUM_BUFS (NUM_BUFS),
    .BI_W     (BI_W)
  ) u_ring (
    .clock    (clock),
    .reset_n  (reset_n),
    .set_mask (set_mask),
    .clr      (retire_go),
    .adv      (retire_go),
    .full     (full),
    .ptr      (ptr),
    .next_ptr (next_ptr)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      eng_buf   <= '0;
    end else begin
      eng_start <= 1'b0;
      eng_abort <= 1'b0;
      if (abort_req) begin
        state     <= IDLE;
        eng_abort <= (state != IDLE);
      end else begin
        case (state)
          IDLE: if (start_req && full[ptr]) begin
            state     <= ISSUE;
            eng_start <= 1'b1;
            eng_buf   <= ptr;
          end
          ISSUE: state <= BUSY;
          BUSY:  if (eng_done) state <= RETIRE;
          RETIRE: if (cont && full[next_ptr]) begin
            state     <= ISSUE;
            eng_start <= 1'b1;
            eng_buf   <= next_ptr;
          end else begin
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cont      <= 1'b0;
      frame_cnt <= '0;
      err       <= '0;
    end else begin
      if (wr_ctrl) cont <= dataIn[CTRL_CONT];
      if (wr_frames)      frame_cnt <= '0;
      else if (retire_go) frame_cnt <= frame_cnt + CNT_W'(1);
      err <= (err & ~(wr_err ? dataIn[1:0] : 2'b00)) | {ovr_ev, nobuf_ev};
    end
  end

`ifdef MPEG2ENC_IRQ_EN
  logic [1:0] irq_pend, irq_mask, pend_next;
  logic       wr_irq, wr_irq_mask;

  assign wr_irq      = wr_en && (addr == ADDR_W'(REG_IRQ));
  assign wr_irq_mask = wr_en && (addr == ADDR_W'(REG_IRQ_MASK));
  assign pend_next   = (irq_pend & ~(wr_irq ? dataIn[1:0] : 2'b00))
                     | {nobuf_ev | ovr_ev, retire_go};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      irq_pend <= '0;
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      irq_pend <= pend_next;
      if (wr_irq_mask) irq_mask <= dataIn[1:0];
      irq <= |(pend_next & irq_mask);
    end
  end
`endif

  always_comb begin
    dataOut = '0;
    if (rd_en) begin
      case (addr)
        ADDR_W'(REG_CTRL): begin
          dataOut[ST_IDLE]       = (state == IDLE);
          dataOut[ST_STATE +: 2] = state;
          dataOut[ST_CONT]       = cont;
          dataOut[ST_FULL +: 8]  = 8'(full);
          dataOut[ST_PTR +: 3]   = 3'(ptr);
        end
        ADDR_W'(REG_FILL):   dataOut = 32'(full);
        ADDR_W'(REG_FRAMES): dataOut = 32'(frame_cnt);
        ADDR_W'(REG_ERR):    dataOut = 32'(err);
`ifdef MPEG2ENC_IRQ_EN
        ADDR_W'(REG_IRQ):      dataOut = 32'(irq_pend);
        ADDR_W'(REG_IRQ_MASK): dataOut = 32'(irq_mask);
`endif
        default: dataOut = '0;
      endcase
    end
  end

endmodule
